// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and issue: up to two pushes and
// two pops per cycle, presenting the four oldest entries as a window.
module fetch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned INS_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               push_cnt,
  input  logic [INS_W-1:0]         push_ins_0,
  input  logic [INS_W-1:0]         push_ins_1,
  output logic                     push_ready,
  input  logic [1:0]               pop_cnt,
  input  logic                     flush,
  output logic [3:0]               win_vld,
  output logic [INS_W-1:0]         win_ins_0,
  output logic [INS_W-1:0]         win_ins_1,
  output logic [INS_W-1:0]         win_ins_2,
  output logic [INS_W-1:0]         win_ins_3,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  logic             err_q, err_d;
  logic [INS_W-1:0] mem_q [DEPTH];
  logic [INS_W-1:0] mem_d [DEPTH];

  logic [1:0]       pop_req, push_req, push_eff;
  logic [PW:0]      pop_eff;
  logic             pop_err, push_err;
  logic [INS_W-1:0] win_ins [4];

  // Free space comes from registered occupancy only; a same-cycle pop is not credited.
  assign push_ready = (count_q <= (PW+1)'(DEPTH - 2));

  always_comb begin
    pop_req  = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
    pop_eff  = ((PW+1)'(pop_req) > count_q) ? count_q : (PW+1)'(pop_req);
    pop_err  = (pop_cnt == 2'd3) || ((PW+1)'(pop_req) > count_q);
    push_req = (push_cnt == 2'd3) ? 2'd0 : push_cnt;
    push_eff = push_ready ? push_req : 2'd0;
    push_err = (push_cnt == 2'd3) || ((push_req != 2'd0) && !push_ready);

    for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    head_d  = head_q + PW'(pop_eff);
    tail_d  = tail_q + PW'(push_eff);
    count_d = count_q - pop_eff + (PW+1)'(push_eff);
    err_d   = err_q | pop_err | push_err;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      err_d   = err_q;
    end else begin
      if (push_eff != 2'd0) mem_d[tail_q] = push_ins_0;
      if (push_eff == 2'd2) mem_d[tail_q + PW'(1)] = push_ins_1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; invalid window slots are masked to zero.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      win_vld[k] = (count_q > (PW+1)'(k));
      win_ins[k] = win_vld[k] ? mem_q[head_q + PW'(k)] : '0;
    end
  end

  assign win_ins_0 = win_ins[0];
  assign win_ins_1 = win_ins[1];
  assign win_ins_2 = win_ins[2];
  assign win_ins_3 = win_ins[3];
  assign count     = count_q;
  assign err       = err_q;

endmodule
